// File: rtl/insn_encode.sv
`default_nettype none
// ============================================================================
// insn_encode : packs RV32I fields into instruction words, two-stage valid/ready
//               pipeline with immediate range check and sequential PC tagging
// Revision    : 1.0
// ============================================================================
module insn_encode #(
   parameter int unsigned       DWIDTH  = 32,
   parameter int unsigned       AWIDTH  = 32,
   parameter logic [AWIDTH-1:0] PC_BASE = 32'h0100_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [6:0]        opcode_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [DWIDTH-1:0] imm_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] insn_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic              err_o
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [6:0]        op;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic [DWIDTH-1:0] imm;
   } fields_t;

   fields_t           s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DWIDTH-1:0] insn_q, insn_d;
   logic              err_q, err_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;

   logic              w_adv1, w_adv2, w_accept, w_move;
   logic [DWIDTH-1:0] w_imm;
   logic              w_fits12, w_fits13, w_fits21, w_shamt_ok;
   logic [DWIDTH-1:0] w_enc_insn;
   logic              w_enc_err;

   assign w_adv2   = !s2_valid_q || ready_i;
   assign w_adv1   = !s1_valid_q || w_adv2;
   assign ready_o  = w_adv1 && !clear_i;
   assign w_accept = valid_i && ready_o;
   assign w_move   = s1_valid_q && w_adv2 && !clear_i;

   // An immediate fits an N-bit signed field when every bit from N-1 upward agrees.
   assign w_imm      = s1_q.imm;
   assign w_fits12   = (&w_imm[DWIDTH-1:11]) | ~(|w_imm[DWIDTH-1:11]);
   assign w_fits13   = (&w_imm[DWIDTH-1:12]) | ~(|w_imm[DWIDTH-1:12]);
   assign w_fits21   = (&w_imm[DWIDTH-1:20]) | ~(|w_imm[DWIDTH-1:20]);
   assign w_shamt_ok = ~(|w_imm[DWIDTH-1:5]);

   always_comb begin
      w_enc_insn = 32'h0000_0013;
      w_enc_err  = 1'b1;
      case (s1_q.op)
         OP_R: begin
            w_enc_insn = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
            w_enc_err  = 1'b0;
         end
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            if (s1_q.op == OP_IMM && (s1_q.f3 == 3'b001 || s1_q.f3 == 3'b101)) begin
               w_enc_insn = {s1_q.f7, w_imm[4:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
               w_enc_err  = ~w_shamt_ok;
            end else begin
               w_enc_insn = {w_imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
               w_enc_err  = ~w_fits12;
            end
         end
         OP_STORE: begin
            w_enc_insn = {w_imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, w_imm[4:0], s1_q.op};
            w_enc_err  = ~w_fits12;
         end
         OP_BRANCH: begin
            w_enc_insn = {w_imm[12], w_imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                          w_imm[4:1], w_imm[11], s1_q.op};
            w_enc_err  = w_imm[0] | ~w_fits13;
         end
         OP_LUI, OP_AUIPC: begin
            w_enc_insn = {w_imm[31:12], s1_q.rd, s1_q.op};
            w_enc_err  = |w_imm[11:0];
         end
         OP_JAL: begin
            w_enc_insn = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], s1_q.rd, s1_q.op};
            w_enc_err  = w_imm[0] | ~w_fits21;
         end
         default: ;
      endcase
   end

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      insn_d     = insn_q;
      err_d      = err_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      if (clear_i) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         cnt_d      = PC_BASE;
      end else begin
         if (w_adv1) s1_valid_d = w_accept;
         if (w_accept) s1_d = '{op: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                                f3: funct3_i, f7: funct7_i, imm: imm_i};
         if (w_adv2) s2_valid_d = s1_valid_q;
         // The PC is bound at the S1->S2 move so stalls never skip or reuse a value.
         if (w_move) begin
            insn_d = w_enc_insn;
            err_d  = w_enc_err;
            pc_d   = cnt_q;
            cnt_d  = cnt_q + AWIDTH'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         insn_q     <= '0;
         err_q      <= 1'b0;
         pc_q       <= PC_BASE;
         cnt_q      <= PC_BASE;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         insn_q     <= insn_d;
         err_q      <= err_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   assign valid_o = s2_valid_q;
   assign insn_o  = insn_q;
   assign pc_o    = pc_q;
   assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_encode.sv
`default_nettype none
// ============================================================================
// tb_insn_encode : vector table, corner sequences and random scoreboard for insn_encode
// Revision       : 1.0
// ============================================================================
module tb_insn_encode;

   localparam logic [31:0] PC_BASE = 32'h0100_0000;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_insn;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] insn;
      logic        err;
   } res_t;

   typedef struct packed {
      logic [31:0] insn;
      logic        err;
      logic [31:0] pc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [6:0]  opcode_i = '0;
   logic [4:0]  rd_i = '0;
   logic [4:0]  rs1_i = '0;
   logic [4:0]  rs2_i = '0;
   logic [2:0]  funct3_i = '0;
   logic [6:0]  funct7_i = '0;
   logic [31:0] imm_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [31:0] insn_o;
   logic [31:0] pc_o;
   logic        err_o;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t tbl [14];
   sb_t  sbq [$];
   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

   insn_encode #(.DWIDTH(32), .AWIDTH(32), .PC_BASE(PC_BASE)) dut (
      .clk(clk), .rst(rst), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o),
      .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
      .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .pc_o(pc_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference encoder: field placement by multiplication/division, range checks as signed bounds.
   function automatic res_t model(input vec_t v);
      res_t        r;
      int unsigned u   = v.imm;
      longint      s   = longint'($signed(v.imm));
      int unsigned op  = 32'(v.op);
      int unsigned rd  = 32'(v.rd);
      int unsigned rs1 = 32'(v.rs1);
      int unsigned rs2 = 32'(v.rs2);
      int unsigned f3  = 32'(v.f3);
      int unsigned f7  = 32'(v.f7);
      int unsigned w;
      logic        e;
      case (op)
         32'h33: begin
            w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
            e = 1'b0;
         end
         32'h13, 32'h03, 32'h67, 32'h73: begin
            if (op == 32'h13 && (f3 == 1 || f3 == 5)) begin
               w = f7 * 2**25 + (u % 32) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
               e = (u > 31);
            end else begin
               w = (u % 4096) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
               e = (s < -2048 || s > 2047);
            end
         end
         32'h23: begin
            w = ((u / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
                + (u % 32) * 2**7 + op;
            e = (s < -2048 || s > 2047);
         end
         32'h63: begin
            w = ((u / 4096) % 2) * 2**31 + ((u / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15
                + f3 * 2**12 + ((u / 2) % 16) * 2**8 + ((u / 2048) % 2) * 2**7 + op;
            e = (u % 2 == 1) || s < -4096 || s > 4095;
         end
         32'h37, 32'h17: begin
            w = (u / 4096) * 4096 + rd * 2**7 + op;
            e = (u % 4096 != 0);
         end
         32'h6F: begin
            w = ((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21 + ((u / 2048) % 2) * 2**20
                + ((u / 4096) % 256) * 2**12 + rd * 2**7 + op;
            e = (u % 2 == 1) || s < -1048576 || s > 1048575;
         end
         default: begin
            w = 32'h13;
            e = 1'b1;
         end
      endcase
      r.insn = w;
      r.err  = e;
      return r;
   endfunction

   task automatic apply(input vec_t v);
      opcode_i = v.op;  rd_i = v.rd;  rs1_i = v.rs1;  rs2_i = v.rs2;
      funct3_i = v.f3;  funct7_i = v.f7;  imm_i = v.imm;
   endtask

   function automatic vec_t cur_vec();
      vec_t v;
      v = '0;
      v.op = opcode_i;  v.rd = rd_i;  v.rs1 = rs1_i;  v.rs2 = rs2_i;
      v.f3 = funct3_i;  v.f7 = funct7_i;  v.imm = imm_i;
      return v;
   endfunction

   function automatic vec_t addi_vec(input logic [31:0] imm);
      vec_t v;
      v = '0;
      v.op = 7'h13;  v.rd = 5'd1;  v.imm = imm;
      return v;
   endfunction

   // One word through an idle pipeline: accepted, invisible after one edge, visible after two.
   task automatic run_one(input vec_t v, input logic [31:0] exp_pc, input string nm);
      @(negedge clk);
      apply(v);  valid_i = 1'b1;  ready_i = 1'b1;
      #1 chk({nm, "_rdy"}, ready_o, 1);
      @(negedge clk);
      valid_i = 1'b0;
      #1 chk({nm, "_lat0"}, valid_o, 0);
      @(negedge clk);
      #1;
      chk({nm, "_valid"}, valid_o, 1);
      chk({nm, "_insn"}, insn_o, v.exp_insn);
      chk({nm, "_err"}, err_o, v.exp_err);
      chk({nm, "_pc"}, pc_o, exp_pc);
   endtask

   task automatic do_clear();
      @(negedge clk);
      valid_i = 1'b0;  clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   task automatic rand_fields();
      int m;
      m = $urandom_range(0, 5);
      opcode_i = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) opcode_i = 7'($urandom);
      rd_i = 5'($urandom);  rs1_i = 5'($urandom);  rs2_i = 5'($urandom);
      funct3_i = 3'($urandom);  funct7_i = 7'($urandom);
      case (m)
         0:       imm_i = $urandom;
         1:       imm_i = 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       imm_i = 32'($urandom_range(0, 63));
         3:       imm_i = $urandom & 32'hFFFF_F000;
         4:       imm_i = 32'($urandom_range(0, 4194303)) - 32'd2097152;
         default: imm_i = 32'($urandom_range(0, 4099)) - 32'd2050;
      endcase
   endtask

   initial begin
      vec_t        w [3];
      logic [31:0] h_insn, h_pc, p_insn, p_pc;
      logic [31:0] pc_model;
      logic        prev_stall;
      int          got;
      res_t        r;
      sb_t         e;

      tbl[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0050_0093, 1'b0};
      tbl[1]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020_A423, 1'b0};
      tbl[2]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
      tbl[3]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
      tbl[4]  = '{7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd4,         32'h4041_D193, 1'b0};
      tbl[5]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0020_81B3, 1'b0};
      tbl[6]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0020_00EF, 1'b1};
      tbl[7]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h8000_0093, 1'b1};
      tbl[8]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd5,         32'h0000_0013, 1'b1};
      tbl[9]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
      tbl[10] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFF_F0EF, 1'b0};
      tbl[11] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1};
      tbl[12] = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd32,        32'h0000_9093, 1'b1};
      tbl[13] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h8000_0063, 1'b1};

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_insn", insn_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_pc", pc_o, PC_BASE);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++)
         run_one(tbl[i], PC_BASE + 32'(4 * i), $sformatf("vec%0d", i));

      // Backpressure: two accepts fill the pipeline, the third waits for ready_i
      do_clear();
      for (int k = 0; k < 3; k++) begin
         w[k] = addi_vec(32'(k + 1));
         r = model(w[k]);
         w[k].exp_insn = r.insn;
      end
      @(negedge clk);
      ready_i = 1'b0;  apply(w[0]);  valid_i = 1'b1;
      #1 chk("bp_rdy0", ready_o, 1);
      @(negedge clk);
      apply(w[1]);
      #1 chk("bp_rdy1", ready_o, 1);
      @(negedge clk);
      apply(w[2]);
      #1;
      chk("bp_rdy2", ready_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_insn", insn_o, w[0].exp_insn);
      h_insn = insn_o;  h_pc = pc_o;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("bp_hold_rdy", ready_o, 0);
         chk("bp_hold_v", valid_o, 1);
         chk("bp_hold_insn", insn_o, h_insn);
         chk("bp_hold_pc", pc_o, h_pc);
      end
      @(negedge clk);
      ready_i = 1'b1;
      #1 chk("bp_rdy3", ready_o, 1);
      got = 0;
      for (int c = 0; c < 8 && got < 3; c++) begin
         if (c > 0) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
         end
         if (valid_o) begin
            chk($sformatf("bp_out%0d_insn", got), insn_o, w[got].exp_insn);
            chk($sformatf("bp_out%0d_pc", got), pc_o, PC_BASE + 32'(4 * got));
            got++;
         end
      end
      valid_i = 1'b0;
      chk("bp_count", got, 3);

      // Clear with a full pipeline and an offered input
      @(negedge clk);
      ready_i = 1'b0;  apply(w[0]);  valid_i = 1'b1;
      @(negedge clk);
      apply(w[1]);
      @(negedge clk);
      clear_i = 1'b1;  ready_i = 1'b1;  apply(w[2]);
      #1;
      chk("clr_full", valid_o, 1);
      chk("clr_rdy", ready_o, 0);
      @(negedge clk);
      clear_i = 1'b0;  valid_i = 1'b0;
      #1 chk("clr_valid", valid_o, 0);
      repeat (2) begin
         @(negedge clk);
         #1 chk("clr_empty", valid_o, 0);
      end
      run_one(tbl[0], PC_BASE, "clr_after");

      // Asynchronous reset mid-stream
      @(negedge clk);
      ready_i = 1'b1;  valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         apply(w[k]);
         @(negedge clk);
      end
      @(posedge clk);
      #2;
      chk("arst_pre_valid", valid_o, 1);
      rst = 1'b0;
      #1;
      chk("arst_valid", valid_o, 0);
      chk("arst_pc", pc_o, PC_BASE);
      chk("arst_insn", insn_o, 0);
      chk("arst_err", err_o, 0);
      @(negedge clk);
      valid_i = 1'b0;
      rst = 1'b1;
      run_one(tbl[3], PC_BASE, "arst_after");

      // Random traffic against the scoreboard
      do_clear();
      pc_model = PC_BASE;
      prev_stall = 1'b0;
      p_insn = '0;
      p_pc = '0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 3) != 0);
         rand_fields();
         #1;
         if (prev_stall) begin
            chk("rnd_hold_v", valid_o, 1);
            chk("rnd_hold_insn", insn_o, p_insn);
            chk("rnd_hold_pc", pc_o, p_pc);
         end
         if (valid_o && ready_i) begin
            chk("rnd_sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("rnd_insn", insn_o, e.insn);
               chk("rnd_err", err_o, e.err);
               chk("rnd_pc", pc_o, e.pc);
            end
         end
         if (valid_i && ready_o) begin
            r = model(cur_vec());
            sbq.push_back('{insn: r.insn, err: r.err, pc: pc_model});
            pc_model = pc_model + 32'd4;
         end
         prev_stall = valid_o && !ready_i;
         p_insn = insn_o;
         p_pc = pc_o;
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int c = 0; c < 10 && sbq.size() > 0; c++) begin
         #1;
         if (valid_o) begin
            e = sbq.pop_front();
            chk("drain_insn", insn_o, e.insn);
            chk("drain_err", err_o, e.err);
            chk("drain_pc", pc_o, e.pc);
         end
         @(negedge clk);
      end
      chk("drain_empty", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
